// File: rtl/rad4_mult.sv
// rad4_mult: iterative unsigned multiplier using radix-4 Booth recoding.
// One Booth digit of y is applied per enabled clock edge; the product is
// published on out after DIGITS+1 enabled edges, counting the capture edge.
//
// Ports:
//   clk   - clock, all state changes on its rising edge
//   rst_n - asynchronous active-low reset
//   en    - enable/start; en=0 freezes all state
//   x     - unsigned multiplicand, 2*DIGITS bits
//   y     - unsigned multiplier (Booth-recoded), 2*DIGITS bits
//   out   - registered product x*y, 4*DIGITS bits
module rad4_mult #(
    parameter int unsigned DIGITS = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2*DIGITS-1:0]   x,
    input  logic [2*DIGITS-1:0]   y,
    output logic [4*DIGITS-1:0]   out
);

    localparam int unsigned OP_W   = 2 * DIGITS;
    localparam int unsigned PROD_W = 4 * DIGITS;
    localparam int unsigned ACC_W  = 4 * DIGITS + 3;
    localparam int unsigned YR_W   = OP_W + 3;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_t;

    // Map a Booth triplet (y[2i+1], y[2i], y[2i-1]) to a signed digit.
    function automatic booth_t booth_decode(input logic [2:0] t);
        booth_t d;
        d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
        case (t)
            3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
            3'b011:         d = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
            3'b100:         d = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
            3'b101, 3'b110: d = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
            default:        d = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
        endcase
        return d;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   mcand, mcand_nxt;   // x * 4^i for the next digit
    logic [YR_W-1:0]    yr, yr_nxt;         // remaining y bits, bit 0 = y[2i-1]
    logic [PROD_W-1:0]  out_nxt;

    logic [2:0]         trip;
    booth_t             dig;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   mc_base;
    logic [ACC_W-1:0]   mag;
    logic [ACC_W-1:0]   sum;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            mcand <= '0;
            yr    <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            acc   <= acc_nxt;
            mcand <= mcand_nxt;
            yr    <= yr_nxt;
            out   <= out_nxt;
        end
    end

    // Next-state, partial-product accumulation and result publication.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = acc;
        mcand_nxt = mcand;
        yr_nxt    = yr;
        out_nxt   = out;

        // The capture edge applies d_0 straight from the inputs with a cleared accumulator.
        if (state == IDLE) begin
            trip     = {y[1:0], 1'b0};
            acc_base = '0;
            mc_base  = ACC_W'(x);
        end else begin
            trip     = yr[2:0];
            acc_base = acc;
            mc_base  = mcand;
        end

        dig = booth_decode(trip);
        mag = dig.zero ? '0 : (dig.two ? (mc_base << 1) : mc_base);
        sum = dig.neg ? (acc_base - mag) : (acc_base + mag);

        if (en) begin
            acc_nxt   = sum;
            mcand_nxt = mc_base << 2;
            if (state == IDLE) begin
                yr_nxt    = YR_W'({2'b00, y, 1'b0} >> 2);
                count_nxt = CNT_W'(1);
                state_nxt = BUSY;
            end else begin
                yr_nxt    = yr >> 2;
                count_nxt = count + CNT_W'(1);
                if (count == CNT_W'(DIGITS)) begin
                    out_nxt   = sum[PROD_W-1:0];
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rad4_mult.sv
// Directed bench for rad4_mult at DIGITS=128, 4 and 8.
module tb_rad4_mult;

    logic          clk;
    logic          rst_n;

    logic          en128;
    logic [255:0]  x128, y128;
    logic [511:0]  out128;

    logic          en4;
    logic [7:0]    x4, y4;
    logic [15:0]   out4;

    logic          en8;
    logic [15:0]   x8, y8;
    logic [31:0]   out8;

    int            n_checks;
    int            n_errors;
    logic [15:0]   prev4;

    rad4_mult #(.DIGITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .en(en128), .x(x128), .y(y128), .out(out128)
    );

    rad4_mult #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .x(x4), .y(y4), .out(out4)
    );

    rad4_mult #(.DIGITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .x(x8), .y(y8), .out(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DIGITS=4 product: out must hold its previous value until edge 5.
    task automatic run4(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        x4  = a;
        y4  = b;
        en4 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("hold4", 512'(out4), 512'(prev4));
        end
        tick();
        chk("prod4", 512'(out4), 512'(e));
        prev4 = e;
        en4   = 1'b0;
    endtask

    initial begin
        logic [31:0] pend;
        logic [31:0] exp8;

        n_checks = 0;
        n_errors = 0;
        prev4    = 16'd0;
        rst_n    = 1'b0;
        en128 = 1'b0; x128 = '0; y128 = '0;
        en4   = 1'b0; x4   = '0; y4   = '0;
        en8   = 1'b0; x8   = '0; y8   = '0;

        #2;
        chk("rst_out128", out128, 512'd0);
        chk("rst_out4", 512'(out4), 512'd0);
        chk("rst_out8", 512'(out8), 512'd0);

        // DIGITS=128, 10*5 with en held from reset release.
        tick();
        en128 = 1'b1;
        x128  = 256'd10;
        y128  = 256'd5;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 128; e++) begin
            tick();
            chk("lat128", out128, 512'd0);
        end
        tick();
        chk("prod128", out128, 512'd50);
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("stable128", out128, 512'd50);
        end
        en128 = 1'b0;

        // DIGITS=4 directed products.
        run4(8'hFF, 8'hFF, 16'd65025);
        run4(8'h7F, 8'hAA, 16'h5456);
        run4(8'h00, 8'hFF, 16'd0);
        run4(8'hFF, 8'h00, 16'd0);

        // Pause for 3 cycles after edge 2; operand changes during the pause are ignored.
        x4  = 8'd3;
        y4  = 8'd7;
        en4 = 1'b1;
        tick();
        tick();
        en4 = 1'b0;
        x4  = 8'hFF;
        y4  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause4", 512'(out4), 512'd0);
        end
        en4 = 1'b1;
        tick();
        chk("resume4", 512'(out4), 512'd0);
        tick();
        chk("resume4", 512'(out4), 512'd0);
        tick();
        chk("pause_prod4", 512'(out4), 512'd21);
        en4 = 1'b0;

        // Short reset pulse mid-operation, then a clean restart.
        x4  = 8'd13;
        y4  = 8'd11;
        en4 = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst4", 512'(out4), 512'd0);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rst_lat4", 512'(out4), 512'd0);
        end
        tick();
        chk("rst_prod4", 512'(out4), 512'd143);
        en4 = 1'b0;

        // DIGITS=8 back-to-back with operands changing every cycle.
        en8  = 1'b1;
        pend = 32'd0;
        exp8 = 32'd0;
        for (int k = 0; k < 54; k++) begin
            if (k == 0) begin
                x8 = 16'hFFFF;
                y8 = 16'hFFFF;
            end else begin
                x8 = 16'($urandom);
                y8 = 16'($urandom);
            end
            if (k % 9 == 0)
                pend = 32'(x8) * 32'(y8);
            tick();
            if (k % 9 == 8)
                exp8 = pend;
            chk("rand8", 512'(out8), 512'(exp8));
        end
        en8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
